phaser_in_rdctl: RTL
====================

// Module: phaser_in_rdctl
// PURPOSE
//  Read-side (capture) control for the DDR PHY byte lane; the receive-direction counterpart of the PHASER_OUT write path.
//  Owns the 6-bit fine capture-delay tap and 3-bit phase select, with step/overflow handling and load/readback.
//  Generates the RDENABLE capture window from BURSTPENDING for the ISERDES/IN_FIFO. Sits between calibration logic and the capture datapath.
// PARAMETERS
//  FINE_DELAY     0   reset value of fine tap, 0..63; other values -> $display + $finish at elaboration
//  PHASE_SEL      0   reset value of phase select, 0..7
//  SETTLE_CYC     4   SYSCLK cycles BUSY stays high after a tap change, 1..15
//  RDEN_LATENCY   5   BURSTPENDING -> RDENABLE delay in cycles, 1..15
//  RD_CYCLES      4   RDENABLE window length per burst, 1..15
// PORTS
//  SYSCLK          in   1  single clock; all logic on posedge
//  RST_N           in   1  reset, synchronous, active-low
//  FINEENABLE      in   1  one-cycle step request for fine tap
//  FINEINC         in   1  step direction: 1 = +1, 0 = -1 (sampled with FINEENABLE)
//  COUNTERLOADEN   in   1  load {phase_sel, tap} from COUNTERLOADVAL
//  COUNTERLOADVAL  in   9  [8:6] phase select, [5:0] fine tap
//  COUNTERREADEN   in   1  capture current {phase_sel, tap} to COUNTERREADVAL
//  BURSTPENDING    in   1  one-cycle pulse per read burst issued
//  COUNTERREADVAL  out  9  readback value
//  FINEOVERFLOW    out  1  sticky: step attempted beyond 63 or below 0
//  BUSY            out  1  tap settling; step requests dropped
//  RDENABLE        out  1  capture window
//  TAPVAL          out  9  live {phase_sel, tap} to the delay line
//  ERRCNT          out  8  dropped-step count (see CONFIGURATION)
// BEHAVIOUR
//  Reset (RST_N=0 at posedge): TAPVAL={PHASE_SEL,FINE_DELAY}; COUNTERREADVAL=0; FINEOVERFLOW=0; BUSY=0; RDENABLE=0;
//   ERRCNT=0; FSM=IDLE; RDEN delay line and window counter cleared. Reset mid-burst or mid-settle aborts both immediately.
//  Tap FSM states IDLE, SETTLE:
//   IDLE + COUNTERLOADEN      -> TAPVAL<=COUNTERLOADVAL, FINEOVERFLOW<=0, settle_cnt<=SETTLE_CYC, go SETTLE.
//   IDLE + FINEENABLE (no load) -> inc at 63 or dec at 0: tap unchanged, FINEOVERFLOW<=1, stay IDLE;
//     otherwise tap+/-1, FINEOVERFLOW<=0, settle_cnt<=SETTLE_CYC, go SETTLE.
//   SETTLE: settle_cnt decrements each cycle; at 1 -> IDLE. BUSY = (state==SETTLE), registered, visible the cycle after the change.
//   SETTLE + COUNTERLOADEN    -> load accepted, settle_cnt restarts at SETTLE_CYC.
//   SETTLE + FINEENABLE       -> dropped; tap unchanged; ERRCNT+1 (saturating, only with macro).
//   Load wins over FINEENABLE in the same cycle; FINEENABLE dropped silently (not counted).
//   Phase select changes only via load; never wraps. Fine tap never wraps.
//  Readback: COUNTERREADEN at cycle t -> COUNTERREADVAL = TAPVAL as registered at end of t, visible t+1; holds otherwise.
//   Simultaneous load + read returns the pre-load value.
//  Read enable: BURSTPENDING at cycle t -> RDENABLE high for cycles t+RDEN_LATENCY .. t+RDEN_LATENCY+RD_CYCLES-1.
//   Delayed pulse reloads a 4-bit window counter with RD_CYCLES; RDENABLE = (cnt != 0), registered.
//   Overlapping bursts retrigger: window extends to RD_CYCLES after the latest delayed pulse; no gap is ever inserted.
//   Read window is independent of BUSY.
// CONFIGURATION
//  Macro PHASER_IN_ERRCNT_EN:
//   defined   -> ERRCNT counts FINEENABLE pulses dropped in SETTLE, saturates at 255, cleared only by reset.
//   undefined -> ERRCNT tied to 8'h00; no counter logic synthesised. Port list identical in both builds.
// STRUCTURE
//  Package phaser_in_pkg: tap FSM state enum (IDLE, SETTLE); TAP_MAX=63; TAP_W=6; PSEL_W=3; CNT_W=9; WIN_W=4.
//  Sub-module phaser_in_rden_gen: BURSTPENDING delay line + window counter; ports SYSCLK, RST_N, BURSTPENDING, RDENABLE.
//  Top holds tap FSM, overflow, readback, optional ERRCNT.
// TESTING
//  Reset defaults: FINE_DELAY=10, PHASE_SEL=2, RST_N low 3 cycles -> TAPVAL=9'h08A, all other outputs 0.
//  Step + settle: FINEENABLE=1, FINEINC=1 at tap 10 -> TAPVAL fine=11, BUSY high exactly 4 cycles;
//   2nd pulse on 2nd BUSY cycle -> dropped, tap stays 11, ERRCNT=1 (macro on) / 0 (off).
//  Boundaries: load 9'h03F then step +1 -> tap 63, FINEOVERFLOW=1; step -1 -> tap 62, FINEOVERFLOW=0;
//   load 0 then step -1 -> tap 0, FINEOVERFLOW=1.
//  Load/read collision: TAPVAL=9'h020, COUNTERLOADEN+COUNTERREADEN with 9'h1C5 -> COUNTERREADVAL=9'h020, TAPVAL=9'h1C5.
//  RDENABLE: BURSTPENDING at cycle 0 -> high cycles 5..8; pulses at 0 and 2 -> high cycles 5..10 continuous;
//   RST_N low at cycle 6 -> RDENABLE 0 from cycle 7, no further window.

Source files
------------

// File: rtl/phaser_in_pkg.sv
// -----------------------------------------------------------------------------
// phaser_in_pkg
// Shared types and constants for the read-side phaser control block.
//   tap_state_t  : tap FSM state (IDLE, SETTLE)
//   TAP_MAX      : largest legal fine-tap value
//   TAP_W/PSEL_W : fine-tap and phase-select widths
//   CNT_W        : packed {phase_sel, tap} width
//   WIN_W        : read-window counter width
// -----------------------------------------------------------------------------
package phaser_in_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        SETTLE = 1'b1
    } tap_state_t;

    localparam int TAP_MAX = 63;
    localparam int TAP_W   = 6;
    localparam int PSEL_W  = 3;
    localparam int CNT_W   = 9;
    localparam int WIN_W   = 4;

    // True when a step in the requested direction would leave 0..TAP_MAX.
    function automatic logic step_blocked(input logic [TAP_W-1:0] tap, input logic inc);
        return inc ? (tap == TAP_W'(TAP_MAX)) : (tap == '0);
    endfunction

endpackage

// File: rtl/phaser_in_rden_gen.sv
// -----------------------------------------------------------------------------
// phaser_in_rden_gen
// Turns each BURSTPENDING pulse into a RDENABLE capture window that opens
// RDEN_LATENCY cycles later and lasts RD_CYCLES cycles. A later burst whose
// delayed pulse arrives while a window is open simply reloads the counter,
// so overlapping windows merge without a gap.
// Ports:
//   SYSCLK        in  clock, all logic on posedge
//   RST_N         in  synchronous active-low reset; clears delay line + window
//   BURSTPENDING  in  one-cycle pulse per read burst
//   RDENABLE      out registered capture window
// -----------------------------------------------------------------------------
module phaser_in_rden_gen
    import phaser_in_pkg::*;
#(
    parameter int unsigned RDEN_LATENCY = 5,
    parameter int unsigned RD_CYCLES    = 4
) (
    input  logic SYSCLK,
    input  logic RST_N,
    input  logic BURSTPENDING,
    output logic RDENABLE
);

    // The window counter itself adds one cycle, so the delay line is one
    // stage shorter than the requested latency.
    localparam int unsigned DLY = RDEN_LATENCY - 1;

    logic pulse_dly;

    generate
        if (DLY == 0) begin : g_nodly
            assign pulse_dly = BURSTPENDING;
        end else begin : g_dly
            logic [DLY-1:0] dly_reg;
            logic [DLY-1:0] dly_next;

            for (genvar gi = 0; gi < DLY; gi++) begin : g_stage
                if (gi == 0) begin : g_first
                    assign dly_next[gi] = BURSTPENDING;
                end else begin : g_rest
                    assign dly_next[gi] = dly_reg[gi-1];
                end
            end

            always_ff @(posedge SYSCLK) begin
                if (!RST_N) begin
                    dly_reg <= '0;
                end else begin
                    dly_reg <= dly_next;
                end
            end

            assign pulse_dly = dly_reg[DLY-1];
        end
    endgenerate

    logic [WIN_W-1:0] win_reg;
    logic [WIN_W-1:0] win_next;
    logic             rden_reg;

    always_comb begin
        win_next = win_reg;
        if (pulse_dly) begin
            win_next = WIN_W'(RD_CYCLES);
        end else if (win_reg != '0) begin
            win_next = win_reg - WIN_W'(1);
        end
    end

    always_ff @(posedge SYSCLK) begin
        if (!RST_N) begin
            win_reg  <= '0;
            rden_reg <= 1'b0;
        end else begin
            win_reg  <= win_next;
            rden_reg <= (win_next != '0);
        end
    end

    assign RDENABLE = rden_reg;

endmodule

// File: rtl/phaser_in_rdctl.sv
// -----------------------------------------------------------------------------
// phaser_in_rdctl
// Read-side capture control for one DDR PHY byte lane. Holds the 6-bit fine
// capture-delay tap and 3-bit phase select, handles step requests with
// overflow detection and a settle interval, supports load/readback from the
// calibration logic, and generates the RDENABLE capture window.
//
// Build option: define PHASER_IN_ERRCNT_EN to count step requests dropped
// while settling (saturating at 255). Without it ERRCNT is constant zero.
//
// Ports:
//   SYSCLK          in   clock, all logic on posedge
//   RST_N           in   synchronous active-low reset
//   FINEENABLE      in   one-cycle fine-tap step request
//   FINEINC         in   step direction, 1 = +1, 0 = -1
//   COUNTERLOADEN   in   load {phase_sel, tap} from COUNTERLOADVAL
//   COUNTERLOADVAL  in   [8:6] phase select, [5:0] fine tap
//   COUNTERREADEN   in   capture live {phase_sel, tap} into COUNTERREADVAL
//   BURSTPENDING    in   one-cycle pulse per read burst
//   COUNTERREADVAL  out  readback value
//   FINEOVERFLOW    out  sticky step-out-of-range flag
//   BUSY            out  tap settling, steps dropped
//   RDENABLE        out  capture window
//   TAPVAL          out  live {phase_sel, tap}
//   ERRCNT          out  dropped-step count (zero unless PHASER_IN_ERRCNT_EN)
// -----------------------------------------------------------------------------
module phaser_in_rdctl
    import phaser_in_pkg::*;
#(
    parameter int unsigned FINE_DELAY   = 0,
    parameter int unsigned PHASE_SEL    = 0,
    parameter int unsigned SETTLE_CYC   = 4,
    parameter int unsigned RDEN_LATENCY = 5,
    parameter int unsigned RD_CYCLES    = 4
) (
    input  logic             SYSCLK,
    input  logic             RST_N,
    input  logic             FINEENABLE,
    input  logic             FINEINC,
    input  logic             COUNTERLOADEN,
    input  logic [CNT_W-1:0] COUNTERLOADVAL,
    input  logic             COUNTERREADEN,
    input  logic             BURSTPENDING,
    output logic [CNT_W-1:0] COUNTERREADVAL,
    output logic             FINEOVERFLOW,
    output logic             BUSY,
    output logic             RDENABLE,
    output logic [CNT_W-1:0] TAPVAL,
    output logic [7:0]       ERRCNT
);

    // Reject out-of-range configurations while elaborating.
    generate
        if (FINE_DELAY > 63 || PHASE_SEL > 7 ||
            SETTLE_CYC < 1 || SETTLE_CYC > 15 ||
            RDEN_LATENCY < 1 || RDEN_LATENCY > 15 ||
            RD_CYCLES < 1 || RD_CYCLES > 15) begin : g_bad_param
            $fatal(1, "phaser_in_rdctl: parameter out of range");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Tap FSM
    // ------------------------------------------------------------------
    tap_state_t        state_reg;
    logic [PSEL_W-1:0] psel_reg;
    logic [TAP_W-1:0]  tap_reg;
    logic              ovf_reg;
    logic              busy_reg;
    logic [3:0]        settle_reg;
    logic [TAP_W-1:0]  tap_step_val;

    assign tap_step_val = FINEINC ? (tap_reg + TAP_W'(1)) : (tap_reg - TAP_W'(1));

    always_ff @(posedge SYSCLK) begin
        if (!RST_N) begin
            state_reg  <= IDLE;
            psel_reg   <= PSEL_W'(PHASE_SEL);
            tap_reg    <= TAP_W'(FINE_DELAY);
            ovf_reg    <= 1'b0;
            busy_reg   <= 1'b0;
            settle_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (COUNTERLOADEN) begin
                        {psel_reg, tap_reg} <= COUNTERLOADVAL;
                        ovf_reg    <= 1'b0;
                        settle_reg <= 4'(SETTLE_CYC);
                        state_reg  <= SETTLE;
                        busy_reg   <= 1'b1;
                    end else if (FINEENABLE) begin
                        if (step_blocked(tap_reg, FINEINC)) begin
                            // Tap saturates rather than wrapping.
                            ovf_reg <= 1'b1;
                        end else begin
                            tap_reg    <= tap_step_val;
                            ovf_reg    <= 1'b0;
                            settle_reg <= 4'(SETTLE_CYC);
                            state_reg  <= SETTLE;
                            busy_reg   <= 1'b1;
                        end
                    end
                end
                SETTLE: begin
                    if (COUNTERLOADEN) begin
                        // A load during settling restarts the settle interval.
                        {psel_reg, tap_reg} <= COUNTERLOADVAL;
                        ovf_reg    <= 1'b0;
                        settle_reg <= 4'(SETTLE_CYC);
                    end else if (settle_reg == 4'd1) begin
                        state_reg <= IDLE;
                        busy_reg  <= 1'b0;
                    end else begin
                        settle_reg <= settle_reg - 4'd1;
                    end
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign TAPVAL       = {psel_reg, tap_reg};
    assign FINEOVERFLOW = ovf_reg;
    assign BUSY         = busy_reg;

    // ------------------------------------------------------------------
    // Readback: samples the pre-update value, so a same-cycle load is not
    // visible until the next read.
    // ------------------------------------------------------------------
    logic [CNT_W-1:0] rdval_reg;

    always_ff @(posedge SYSCLK) begin
        if (!RST_N) begin
            rdval_reg <= '0;
        end else if (COUNTERREADEN) begin
            rdval_reg <= {psel_reg, tap_reg};
        end
    end

    assign COUNTERREADVAL = rdval_reg;

    // ------------------------------------------------------------------
    // Dropped-step counter. A step that loses to a same-cycle load is not
    // an error and is not counted.
    // ------------------------------------------------------------------
`ifdef PHASER_IN_ERRCNT_EN
    logic [7:0] err_reg;
    logic       drop_step;

    assign drop_step = (state_reg == SETTLE) && FINEENABLE && !COUNTERLOADEN;

    always_ff @(posedge SYSCLK) begin
        if (!RST_N) begin
            err_reg <= '0;
        end else if (drop_step && (err_reg != 8'hFF)) begin
            err_reg <= err_reg + 8'd1;
        end
    end

    assign ERRCNT = err_reg;
`else
    assign ERRCNT = 8'h00;
`endif

    // ------------------------------------------------------------------
    // Read-enable window
    // ------------------------------------------------------------------
    phaser_in_rden_gen #(
        .RDEN_LATENCY (RDEN_LATENCY),
        .RD_CYCLES    (RD_CYCLES)
    ) u_rden_gen (
        .SYSCLK       (SYSCLK),
        .RST_N        (RST_N),
        .BURSTPENDING (BURSTPENDING),
        .RDENABLE     (RDENABLE)
    );

endmodule
